// File: rtl/sdram_chip_model.sv
// sdram_chip_model
// Cycle-accurate responder model of one x16 SDR SDRAM device. It sits at the
// far end of the SDRAM pin interface, decodes the command pins, keeps per-bank
// open-row state, obeys the programmed mode (CAS latency, burst length, write
// burst mode), stores data in a reduced internal array and latches the first
// protocol error it sees.
//
// Ports:
//   clk            device clock, everything samples on the rising edge
//   init           asynchronous active-high reset
//   SDRAM_DQ       16-bit bidirectional data bus (driven only with valid read data)
//   SDRAM_A        multiplexed row/column/mode address
//   SDRAM_BA       bank select
//   SDRAM_DQML/H   byte masks (write latency 0, read latency 2)
//   SDRAM_nCS/nRAS/nCAS/nWE  command pins
//   SDRAM_CKE      clock enable, low freezes the whole model
//   mode_valid     a legal LOAD_MODE has been accepted
//   refresh_count  accepted AUTO_REFRESH commands, saturating
//   err/err_code   sticky error flag and code of the first error
//
// Build option:
//   SDRAM_MODEL_REFRESH_CHECK_EN  adds a refresh watchdog (error 8) and data
//   decay: once refresh has been missed for 8x the limit the array reads 16'hDEAD.

module sdram_chip_model #(
  parameter int MEM_AW           = 16,
  parameter int T_RCD            = 2,
  parameter int T_RFC            = 7,
  parameter int MAX_REF_INTERVAL = 1024
) (
  input  logic        clk,
  input  logic        init,
  inout  wire  [15:0] SDRAM_DQ,
  input  logic [12:0] SDRAM_A,
  input  logic [1:0]  SDRAM_BA,
  input  logic        SDRAM_DQML,
  input  logic        SDRAM_DQMH,
  input  logic        SDRAM_nCS,
  input  logic        SDRAM_nRAS,
  input  logic        SDRAM_nCAS,
  input  logic        SDRAM_nWE,
  input  logic        SDRAM_CKE,
  output logic        mode_valid,
  output logic [15:0] refresh_count,
  output logic        err,
  output logic [3:0]  err_code
);

  typedef enum logic [2:0] {
    CMD_LOAD_MODE = 3'b000,
    CMD_REFRESH   = 3'b001,
    CMD_PRECHARGE = 3'b010,
    CMD_ACTIVE    = 3'b011,
    CMD_WRITE     = 3'b100,
    CMD_READ      = 3'b101,
    CMD_RESERVED  = 3'b110,
    CMD_NOP       = 3'b111
  } cmd_e;

  logic [15:0] memArray [2**MEM_AW];

  logic              modeValid_q, modeValid_d;
  logic [1:0]        blLog2_q, blLog2_d;
  logic              clIs3_q, clIs3_d;
  logic              wrSingle_q, wrSingle_d;
  logic [3:0]        bankOpen_q, bankOpen_d;
  logic [3:0][12:0]  bankRow_q, bankRow_d;
  logic [3:0][7:0]   rcdCnt_q, rcdCnt_d;
  logic [7:0]        rfcCnt_q, rfcCnt_d;
  logic [15:0]       refreshCount_q, refreshCount_d;
  logic              err_q, err_d;
  logic [3:0]        errCode_q, errCode_d;
  logic [3:0]        rdLeft_q, rdLeft_d;
  logic              rdWait_q, rdWait_d;
  logic [14:0]       rdBase_q, rdBase_d;
  logic [8:0]        rdCol_q, rdCol_d;
  logic [3:0]        wrLeft_q, wrLeft_d;
  logic [14:0]       wrBase_q, wrBase_d;
  logic [8:0]        wrCol_q, wrCol_d;
  logic [15:0]       dqOut_q, dqOut_d;
  logic              oeLo_q, oeLo_d;
  logic              oeHi_q, oeHi_d;
  logic              dqmLoD1_q, dqmLoD1_d;
  logic              dqmHiD1_q, dqmHiD1_d;
`ifdef SDRAM_MODEL_REFRESH_CHECK_EN
  logic [31:0]       wdCnt_q, wdCnt_d;
  logic              dataLost_q, dataLost_d;
`endif

  logic              memWe;
  logic [MEM_AW-1:0] memIdx;
  logic [15:0]       memData;
  logic [1:0]        memBe;
  logic              raiseErr;
  logic [3:0]        raiseCode;
  cmd_e              cmd;

  assign SDRAM_DQ[7:0]  = oeLo_q ? dqOut_q[7:0]  : 8'hzz;
  assign SDRAM_DQ[15:8] = oeHi_q ? dqOut_q[15:8] : 8'hzz;

  assign mode_valid    = modeValid_q;
  assign refresh_count = refreshCount_q;
  assign err           = err_q;
  assign err_code      = errCode_q;

  // Flat {bank,row,col} address folded onto the reduced array.
  function automatic logic [MEM_AW-1:0] flatIndex(input logic [14:0] base, input logic [8:0] col);
    logic [23:0] flat;
    flat = {base, col};
    return flat[MEM_AW-1:0];
  endfunction

  // Next burst column: low log2(BL) bits count and wrap, upper bits hold.
  function automatic logic [8:0] burstNext(input logic [8:0] col, input logic [1:0] blLog2);
    logic [8:0] mask;
    mask = (9'd1 << blLog2) - 9'd1;
    return (col & ~mask) | ((col + 9'd1) & mask);
  endfunction

  function automatic logic [15:0] readWord(input logic [MEM_AW-1:0] idx, input logic lost);
    return lost ? 16'hDEAD : memArray[idx];
  endfunction

  // Next-state logic. Running bursts advance first; the command sampled on
  // this edge then overrides them, which is how truncation and "write wins"
  // fall out. Low CKE leaves every register at its current value.
  always_comb begin
    modeValid_d    = modeValid_q;
    blLog2_d       = blLog2_q;
    clIs3_d        = clIs3_q;
    wrSingle_d     = wrSingle_q;
    bankOpen_d     = bankOpen_q;
    bankRow_d      = bankRow_q;
    rcdCnt_d       = rcdCnt_q;
    rfcCnt_d       = rfcCnt_q;
    refreshCount_d = refreshCount_q;
    err_d          = err_q;
    errCode_d      = errCode_q;
    rdLeft_d       = rdLeft_q;
    rdWait_d       = rdWait_q;
    rdBase_d       = rdBase_q;
    rdCol_d        = rdCol_q;
    wrLeft_d       = wrLeft_q;
    wrBase_d       = wrBase_q;
    wrCol_d        = wrCol_q;
    dqOut_d        = dqOut_q;
    oeLo_d         = oeLo_q;
    oeHi_d         = oeHi_q;
    dqmLoD1_d      = dqmLoD1_q;
    dqmHiD1_d      = dqmHiD1_q;
`ifdef SDRAM_MODEL_REFRESH_CHECK_EN
    wdCnt_d        = wdCnt_q;
    dataLost_d     = dataLost_q;
`endif
    memWe          = 1'b0;
    memIdx         = '0;
    memData        = '0;
    memBe          = 2'b00;
    raiseErr       = 1'b0;
    raiseCode      = 4'd0;
    cmd            = (!SDRAM_nCS) ? cmd_e'({SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE}) : CMD_NOP;

    if (SDRAM_CKE) begin
      dqmLoD1_d = SDRAM_DQML;
      dqmHiD1_d = SDRAM_DQMH;
      for (int b = 0; b < 4; b++) begin
        if (rcdCnt_q[b] != 8'd0) rcdCnt_d[b] = rcdCnt_q[b] - 8'd1;
      end
      if (rfcCnt_q != 8'd0) rfcCnt_d = rfcCnt_q - 8'd1;

`ifdef SDRAM_MODEL_REFRESH_CHECK_EN
      // Watchdog only runs once the device has been configured.
      if (modeValid_q && wdCnt_q != 32'hFFFF_FFFF) wdCnt_d = wdCnt_q + 32'd1;
      if (wdCnt_q > 32'(MAX_REF_INTERVAL)) begin
        raiseErr  = 1'b1;
        raiseCode = 4'd8;
      end
      if (wdCnt_q > 32'(8 * MAX_REF_INTERVAL)) dataLost_d = 1'b1;
`endif

      // Read pipeline: the DQM used for a word was sampled one edge before
      // its drive edge, i.e. two edges before the host samples it.
      if (rdLeft_q != 4'd0) begin
        if (rdWait_q) begin
          rdWait_d = 1'b0;
        end else begin
`ifdef SDRAM_MODEL_REFRESH_CHECK_EN
          dqOut_d = readWord(flatIndex(rdBase_q, rdCol_q), dataLost_q);
`else
          dqOut_d = readWord(flatIndex(rdBase_q, rdCol_q), 1'b0);
`endif
          oeLo_d   = !dqmLoD1_q;
          oeHi_d   = !dqmHiD1_q;
          rdCol_d  = burstNext(rdCol_q, blLog2_q);
          rdLeft_d = rdLeft_q - 4'd1;
        end
      end else begin
        oeLo_d = 1'b0;
        oeHi_d = 1'b0;
      end

      if (wrLeft_q != 4'd0) begin
        memWe    = 1'b1;
        memIdx   = flatIndex(wrBase_q, wrCol_q);
        memData  = SDRAM_DQ;
        memBe    = {!SDRAM_DQMH, !SDRAM_DQML};
        wrCol_d  = burstNext(wrCol_q, blLog2_q);
        wrLeft_d = wrLeft_q - 4'd1;
      end

      if (rfcCnt_q != 8'd0 && cmd != CMD_NOP && cmd != CMD_RESERVED) begin
        raiseErr  = 1'b1;
        raiseCode = 4'd6;
      end else begin
        case (cmd)
          CMD_LOAD_MODE: begin
            if ((SDRAM_A[6:4] == 3'd2 || SDRAM_A[6:4] == 3'd3) && SDRAM_A[2] == 1'b0) begin
              modeValid_d = 1'b1;
              blLog2_d    = SDRAM_A[1:0];
              clIs3_d     = (SDRAM_A[6:4] == 3'd3);
              wrSingle_d  = SDRAM_A[9];
            end else begin
              raiseErr  = 1'b1;
              raiseCode = 4'd7;
            end
          end
          CMD_ACTIVE: begin
            if (bankOpen_q[SDRAM_BA]) begin
              raiseErr  = 1'b1;
              raiseCode = 4'd2;
            end else begin
              bankOpen_d[SDRAM_BA] = 1'b1;
              bankRow_d[SDRAM_BA]  = SDRAM_A;
              rcdCnt_d[SDRAM_BA]   = 8'(T_RCD - 1);
            end
          end
          CMD_READ, CMD_WRITE: begin
            if (!modeValid_q) begin
              raiseErr  = 1'b1;
              raiseCode = 4'd1;
            end else if (!bankOpen_q[SDRAM_BA]) begin
              raiseErr  = 1'b1;
              raiseCode = 4'd3;
            end else if (rcdCnt_q[SDRAM_BA] != 8'd0) begin
              raiseErr  = 1'b1;
              raiseCode = 4'd4;
            end else begin
              // Any accepted column command ends whatever burst was running.
              oeLo_d   = 1'b0;
              oeHi_d   = 1'b0;
              rdLeft_d = 4'd0;
              wrLeft_d = 4'd0;
              if (cmd == CMD_READ) begin
                rdLeft_d = 4'd1 << blLog2_q;
                rdWait_d = clIs3_q;
                rdBase_d = {SDRAM_BA, bankRow_q[SDRAM_BA]};
                rdCol_d  = SDRAM_A[8:0];
              end else begin
                memWe    = 1'b1;
                memIdx   = flatIndex({SDRAM_BA, bankRow_q[SDRAM_BA]}, SDRAM_A[8:0]);
                memData  = SDRAM_DQ;
                memBe    = {!SDRAM_DQMH, !SDRAM_DQML};
                wrLeft_d = wrSingle_q ? 4'd0 : (4'd1 << blLog2_q) - 4'd1;
                wrBase_d = {SDRAM_BA, bankRow_q[SDRAM_BA]};
                wrCol_d  = burstNext(SDRAM_A[8:0], blLog2_q);
              end
            end
          end
          CMD_PRECHARGE: begin
            oeLo_d   = 1'b0;
            oeHi_d   = 1'b0;
            rdLeft_d = 4'd0;
            wrLeft_d = 4'd0;
            if (SDRAM_A[10]) bankOpen_d = 4'b0000;
            else             bankOpen_d[SDRAM_BA] = 1'b0;
          end
          CMD_REFRESH: begin
            if (bankOpen_q != 4'b0000) begin
              raiseErr  = 1'b1;
              raiseCode = 4'd5;
            end else begin
              if (refreshCount_q != 16'hFFFF) refreshCount_d = refreshCount_q + 16'd1;
              rfcCnt_d = 8'(T_RFC);
`ifdef SDRAM_MODEL_REFRESH_CHECK_EN
              wdCnt_d = 32'd0;
`endif
            end
          end
          default: begin
          end
        endcase
      end

      // Only the first error code is kept; later ones just hold the flag.
      if (raiseErr) begin
        err_d = 1'b1;
        if (!err_q) errCode_d = raiseCode;
      end
    end
  end

  // State registers. The storage array is deliberately not part of reset.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      modeValid_q    <= 1'b0;
      blLog2_q       <= 2'd0;
      clIs3_q        <= 1'b0;
      wrSingle_q     <= 1'b0;
      bankOpen_q     <= 4'b0000;
      bankRow_q      <= '0;
      rcdCnt_q       <= '0;
      rfcCnt_q       <= 8'd0;
      refreshCount_q <= 16'd0;
      err_q          <= 1'b0;
      errCode_q      <= 4'd0;
      rdLeft_q       <= 4'd0;
      rdWait_q       <= 1'b0;
      rdBase_q       <= '0;
      rdCol_q        <= '0;
      wrLeft_q       <= 4'd0;
      wrBase_q       <= '0;
      wrCol_q        <= '0;
      dqOut_q        <= 16'd0;
      oeLo_q         <= 1'b0;
      oeHi_q         <= 1'b0;
      dqmLoD1_q      <= 1'b0;
      dqmHiD1_q      <= 1'b0;
`ifdef SDRAM_MODEL_REFRESH_CHECK_EN
      wdCnt_q        <= 32'd0;
      dataLost_q     <= 1'b0;
`endif
    end else begin
      modeValid_q    <= modeValid_d;
      blLog2_q       <= blLog2_d;
      clIs3_q        <= clIs3_d;
      wrSingle_q     <= wrSingle_d;
      bankOpen_q     <= bankOpen_d;
      bankRow_q      <= bankRow_d;
      rcdCnt_q       <= rcdCnt_d;
      rfcCnt_q       <= rfcCnt_d;
      refreshCount_q <= refreshCount_d;
      err_q          <= err_d;
      errCode_q      <= errCode_d;
      rdLeft_q       <= rdLeft_d;
      rdWait_q       <= rdWait_d;
      rdBase_q       <= rdBase_d;
      rdCol_q        <= rdCol_d;
      wrLeft_q       <= wrLeft_d;
      wrBase_q       <= wrBase_d;
      wrCol_q        <= wrCol_d;
      dqOut_q        <= dqOut_d;
      oeLo_q         <= oeLo_d;
      oeHi_q         <= oeHi_d;
      dqmLoD1_q      <= dqmLoD1_d;
      dqmHiD1_q      <= dqmHiD1_d;
`ifdef SDRAM_MODEL_REFRESH_CHECK_EN
      wdCnt_q        <= wdCnt_d;
      dataLost_q     <= dataLost_d;
`endif
    end
  end

  // Byte-masked array write; suppressed while init is held.
  always_ff @(posedge clk) begin
    if (memWe && !init) begin
      if (memBe[0]) memArray[memIdx][7:0]  <= memData[7:0];
      if (memBe[1]) memArray[memIdx][15:8] <= memData[15:8];
    end
  end

endmodule
